// File: rtl/logic_axi4_stream_fifo_reader_pkg.sv
// Shared constants and pointer helper for the legacy-FIFO to AXI4-Stream reader.
package logic_axi4_stream_fifo_reader_pkg;

  localparam int BUFFER_DEPTH = 3;
  localparam int LEVEL_WIDTH  = 2;
  localparam int DATA_WIDTH   = 8;

  typedef logic [LEVEL_WIDTH-1:0] ptr_t;

  // Circular pointer advance over the three buffer slots.
  function automatic ptr_t ptr_next(input ptr_t ptr);
    ptr_t nxt;
    if (ptr == ptr_t'(BUFFER_DEPTH - 1)) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream handshake bundle with a packed payload.
interface logic_axi4_stream_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport tx (output tvalid, output tdata, input tready);
  modport rx (input tvalid, input tdata, output tready);
endinterface

// File: rtl/logic_axi4_stream_fifo_reader_buffer.sv
// Three-entry circular output buffer; head entry is presented from registers.
module logic_axi4_stream_fifo_reader_buffer
  import logic_axi4_stream_fifo_reader_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [LEVEL_WIDTH-1:0] count
);

  logic [W-1:0] mem [BUFFER_DEPTH];
  ptr_t         head;
  ptr_t         tail;

  // Storage is intentionally not reset; only occupancy qualifies it.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 2'd0;
    end else begin
      if (push) begin
        tail <= ptr_next(tail);
      end
      if (pop) begin
        head <= ptr_next(head);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[head];

endmodule

// File: rtl/logic_axi4_stream_fifo_reader_checker.sv
// Protocol properties for the FIFO reader, bound alongside the design.
module logic_axi4_stream_fifo_reader_checker
  import logic_axi4_stream_fifo_reader_pkg::*;
(
  input logic                   aclk,
  input logic                   areset,
  input logic                   fifo_empty,
  input logic                   fifo_rdreq,
  input logic                   tvalid,
  input logic                   tready,
  input logic [DATA_WIDTH-1:0]  tdata,
  input logic [LEVEL_WIDTH-1:0] level
);

  a_rdreq_not_empty: assert property (@(posedge aclk) disable iff (areset)
    fifo_rdreq |-> !fifo_empty);

  a_level_bound: assert property (@(posedge aclk) disable iff (areset)
    level <= LEVEL_WIDTH'(BUFFER_DEPTH));

  a_payload_stable: assert property (@(posedge aclk) disable iff (areset)
    (tvalid && !tready) |=> (tvalid && $stable(tdata)));

endmodule

// File: rtl/logic_axi4_stream_fifo_reader.sv
// Reads a legacy-mode (1-cycle read latency) FIFO and re-presents its words as an
// AXI4-Stream; rdreq is throttled by occupancy only, never by tready.
module logic_axi4_stream_fifo_reader
  import logic_axi4_stream_fifo_reader_pkg::*;
(
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_q,
  output logic                   fifo_rdreq,
  logic_axi4_stream_if.tx        tx,
  output logic [LEVEL_WIDTH-1:0] level
);

  logic                   pending;
  logic [LEVEL_WIDTH-1:0] count;
  logic                   valid;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  head_data;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pending <= 1'b0;
    end else begin
      pending <= fifo_rdreq;
    end
  end

  // Reserve a slot for the in-flight word so a push never lands on a full buffer.
  always_comb begin
    fifo_rdreq = 1'b0;
    if (!areset && !fifo_empty &&
        (({1'b0, count} + {2'b00, pending}) <= 3'd2)) begin
      fifo_rdreq = 1'b1;
    end else begin
      fifo_rdreq = 1'b0;
    end
  end

  assign valid = (count != 2'd0);
  assign pop   = valid && tx.tready;

  logic_axi4_stream_fifo_reader_buffer #(.W(DATA_WIDTH)) u_buffer (
    .aclk      (aclk),
    .areset    (areset),
    .push      (pending),
    .push_data (fifo_q),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (count)
  );

  assign tx.tvalid = valid;
  assign tx.tdata  = head_data;
  assign level     = count;

endmodule

// File: tb/tb_logic_axi4_stream_fifo_reader.sv
// Self-checking bench: queue-based external FIFO model plus an in-order scoreboard.
module tb_logic_axi4_stream_fifo_reader;
  import logic_axi4_stream_fifo_reader_pkg::*;

  logic                  aclk;
  logic                  areset;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_rdreq;
  logic [1:0]            level;

  logic_axi4_stream_if #(.W(DATA_WIDTH)) axis ();

  logic_axi4_stream_fifo_reader dut (
    .aclk       (aclk),
    .areset     (areset),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .tx         (axis),
    .level      (level)
  );

  logic_axi4_stream_fifo_reader_checker u_chk (
    .aclk       (aclk),
    .areset     (areset),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .tvalid     (axis.tvalid),
    .tready     (axis.tready),
    .tdata      (axis.tdata),
    .level      (level)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  logic [7:0] ext_q[$];
  logic [7:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;
  int rdreq_cnt  = 0;
  int xfer_cnt   = 0;

  // One clock: sample before the edge, then apply FIFO read effects and score transfers.
  task automatic tick();
    logic       s_rst, s_rd, s_v, s_r;
    logic [7:0] s_d, w, e;
    #1;
    s_rst = areset; s_rd = fifo_rdreq; s_v = axis.tvalid; s_r = axis.tready; s_d = axis.tdata;
    @(posedge aclk);
    @(negedge aclk);
    fifo_q = 8'($urandom);
    if (!s_rst) begin
      if (s_v && s_r) begin
        vectors++; xfer_cnt++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL xfer_spurious: got %h, expected no transfer", s_d);
        end else begin
          e = exp_q.pop_front();
          if (s_d !== e) begin
            miscompares++;
            $display("FAIL xfer_data: got %h, expected %h", s_d, e);
          end
        end
      end
      if (s_rd) begin
        vectors++; rdreq_cnt++;
        if (ext_q.size() == 0) begin
          miscompares++;
          $display("FAIL rdreq_when_empty: got rdreq=1, expected 0");
        end else begin
          w = ext_q.pop_front();
          exp_q.push_back(w);
          fifo_q = w;
        end
      end
    end
    fifo_empty = (ext_q.size() == 0);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    ext_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    axis.tready = 1'b0;
    ext_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    tick();
    tick();
    rdreq_cnt = 0;
    xfer_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    push_word(8'h77);
    #1;
    vectors++;
    if (fifo_rdreq !== 1'b0) begin miscompares++; $display("FAIL reset_rdreq: got %b, expected 0", fifo_rdreq); end
    vectors++;
    if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b, expected 0", axis.tvalid); end
    vectors++;
    if (level !== 2'd0) begin miscompares++; $display("FAIL reset_level: got %0d, expected 0", level); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    axis.tready = 1'b1;
    areset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      vectors++;
      if (axis.tvalid !== ((k >= 2) && (k <= 9))) begin
        miscompares++; $display("FAIL stream_tvalid[%0d]: got %b", k, axis.tvalid);
      end else if ((k >= 2) && (k <= 9) && (axis.tdata !== 8'(k - 1))) begin
        miscompares++; $display("FAIL stream_data[%0d]: got %h, expected %h", k, axis.tdata, 8'(k - 1));
      end
    end
    vectors++;
    if (rdreq_cnt != 8) begin miscompares++; $display("FAIL stream_rdreq_count: got %0d, expected 8", rdreq_cnt); end
    vectors++;
    if (xfer_cnt != 8) begin miscompares++; $display("FAIL stream_xfer_count: got %0d, expected 8", xfer_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    areset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 2) begin
        vectors++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h01) begin
          miscompares++; $display("FAIL stall_hold[%0d]: got v=%b d=%h, expected v=1 d=01", k, axis.tvalid, axis.tdata);
        end
      end
    end
    vectors++;
    if (rdreq_cnt != 3) begin miscompares++; $display("FAIL stall_rdreq_count: got %0d, expected 3", rdreq_cnt); end
    vectors++;
    if (level !== 2'd3) begin miscompares++; $display("FAIL stall_level: got %0d, expected 3", level); end
    axis.tready = 1'b1;
    #1;
    vectors++;
    if (fifo_rdreq !== 1'b0) begin miscompares++; $display("FAIL stall_rdreq_pop_cycle: got %b, expected 0", fifo_rdreq); end
    tick();
    vectors++;
    if (fifo_rdreq !== 1'b1) begin miscompares++; $display("FAIL stall_rdreq_resume: got %b, expected 1", fifo_rdreq); end
    for (int k = 0; k < 20 && xfer_cnt < 6; k++) tick();
    vectors++;
    if (xfer_cnt != 6) begin miscompares++; $display("FAIL stall_drain_count: got %0d, expected 6", xfer_cnt); end
  endtask

  task automatic test_random();
    int pushed = 0;
    do_reset();
    areset = 1'b0;
    for (int c = 0; c < 20000 && xfer_cnt < 1000; c++) begin
      axis.tready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && ($urandom % 4) != 0) begin
        push_word(8'($urandom));
        pushed++;
      end
      tick();
    end
    vectors++;
    if (xfer_cnt != 1000) begin miscompares++; $display("FAIL random_xfer_count: got %0d, expected 1000", xfer_cnt); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL random_leftover: got %0d words, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    areset = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (level !== 2'd2) begin miscompares++; $display("FAIL midrst_level_before: got %0d, expected 2", level); end
    areset = 1'b1;
    exp_q.delete();
    tick();
    vectors++;
    if (axis.tvalid !== 1'b0 || level !== 2'd0) begin
      miscompares++; $display("FAIL midrst_cleared: got v=%b level=%0d, expected v=0 level=0", axis.tvalid, level);
    end
    areset = 1'b0;
    axis.tready = 1'b1;
    xfer_cnt = 0;
    for (int k = 0; k < 10 && axis.tvalid !== 1'b1; k++) tick();
    vectors++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h13) begin
      miscompares++; $display("FAIL midrst_first_word: got v=%b d=%h, expected v=1 d=13", axis.tvalid, axis.tdata);
    end
    for (int k = 0; k < 20 && xfer_cnt < 5; k++) tick();
    vectors++;
    if (xfer_cnt != 5) begin miscompares++; $display("FAIL midrst_xfer_count: got %0d, expected 5", xfer_cnt); end
  endtask

  task automatic test_gap();
    do_reset();
    push_word(8'hA5);
    areset = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++;
    if (level !== 2'd1 || fifo_rdreq !== 1'b0) begin
      miscompares++; $display("FAIL gap_idle: got level=%0d rdreq=%b, expected 1 and 0", level, fifo_rdreq);
    end
    axis.tready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL gap_spurious_tvalid[%0d]: got 1, expected 0", k); end
    end
    push_word(8'h5A);
    #1;
    vectors++;
    if (fifo_rdreq !== 1'b1) begin miscompares++; $display("FAIL gap_rdreq: got %b, expected 1", fifo_rdreq); end
    tick();
    vectors++;
    if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL gap_early_tvalid: got 1, expected 0"); end
    tick();
    vectors++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h5A) begin
      miscompares++; $display("FAIL gap_word: got v=%b d=%h, expected v=1 d=5a", axis.tvalid, axis.tdata);
    end
    tick();
    vectors++;
    if (xfer_cnt != 2) begin miscompares++; $display("FAIL gap_xfer_count: got %0d, expected 2", xfer_cnt); end
  endtask

  initial begin
    areset = 1'b1;
    fifo_empty = 1'b1;
    fifo_q = 8'h00;
    axis.tready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_reset_mid();
    test_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
